round_controller: RTL

- Game-round sequencer for the memory-matrix game. It requests a fresh non-zero 8-cell pattern from the board generator and shows it on the LEDs for a fixed interval, then blanks it.
- It then collects the player's guess from the switches, compares the guess to the pattern, and updates score and lives.
- Sits between the board generator/datapath, the switch/key inputs and the LED/score display logic.

---
 rtl/round_pkg.sv | 8 +
 rtl/round_timer.sv | 15 +
 rtl/round_controller.sv | 137 +++++++++++++
 3 files changed

// File: rtl/round_pkg.sv
// round_pkg: shared FSM state encoding and LED source selects for round_controller
package round_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_SHOW, ST_INPUT, ST_CHECK, ST_OVER} state_e;
  localparam logic [1:0] LED_OFF   = 2'd0;
  localparam logic [1:0] LED_PAT   = 2'd1;
  localparam logic [1:0] LED_GUESS = 2'd2;
  localparam int TMR_W = 32;
endpackage

// File: rtl/round_timer.sv
// round_timer: loadable down-counter that stops at zero; done_o is high while the count is zero
// ports: clk, rst (sync, active-high), load_i/val_i (load count), done_o
module round_timer #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= load_i ? val_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  assign done_o = cnt_q == '0;
endmodule

// File: rtl/round_controller.sv
// round_controller: memory-matrix game round sequencer (request, show, input, check, score/lives)
// ports: clk, reset (sync, active-high); start/submit levels (edge detected); board/board_valid/board_req
// generator handshake; guess switches; led, score, lives, round_win, round_lose, game_over outputs.
// optional: define ROUND_TIMEOUT_EN to turn an unanswered INPUT window into a lost round.
import round_pkg::*;
module round_controller #(
  parameter int SHOW_CYCLES  = 25000000,
  parameter int INPUT_CYCLES = 100000000,
  parameter int START_LIVES  = 3,
  parameter int SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         board,
  input  logic               board_valid,
  output logic               board_req,
  input  logic [7:0]         guess,
  input  logic               submit,
  output logic [7:0]         led,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               round_win,
  output logic               round_lose,
  output logic               game_over
);
  state_e state_q, state_d;
  logic [7:0] pattern_q, pattern_d, guess_q, guess_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0] lives_q, lives_d, lives_dec;
  logic win_q, win_d, lose_q, lose_d, over_q;
  logic start_q, submit_q, start_rise, submit_rise;
  logic [1:0] led_sel;
  logic tmr_load, tmr_done;
  assign start_rise  = start & ~start_q;
  assign submit_rise = submit & ~submit_q;
  assign lives_dec   = lives_q - 3'd1;
  // The timer is reloaded on every entry to SHOW or INPUT; only SHOW depends on it unless the timeout is built in.
  assign tmr_load = (state_d != state_q) && (state_d == ST_SHOW || state_d == ST_INPUT);
  round_timer #(.W(TMR_W)) u_timer (
    .clk(clk),
    .rst(reset),
    .load_i(tmr_load),
    .val_i(state_d == ST_SHOW ? TMR_W'(SHOW_CYCLES - 1) : TMR_W'(INPUT_CYCLES - 1)),
    .done_o(tmr_done)
  );
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    guess_d   = guess_q;
    score_d   = score_q;
    lives_d   = lives_q;
    win_d     = 1'b0;
    lose_d    = 1'b0;
    led_sel   = LED_OFF;
    board_req = 1'b0;
    case (state_q)
      ST_REQ: begin
        board_req = 1'b1;
        if (board_valid && board != 8'h00) begin
          pattern_d = board;
          state_d   = ST_SHOW;
        end
      end
      ST_SHOW: begin
        led_sel = LED_PAT;
        if (tmr_done) state_d = ST_INPUT;
      end
      ST_INPUT: begin
        led_sel = LED_GUESS;
        if (submit_rise) begin
          guess_d = guess;
          state_d = ST_CHECK;
        end
`ifdef ROUND_TIMEOUT_EN
        else if (tmr_done) begin
          guess_d = ~pattern_q;
          state_d = ST_CHECK;
        end
`endif
      end
      ST_CHECK: begin
        if (guess_q == pattern_q) begin
          win_d   = 1'b1;
          score_d = &score_q ? score_q : score_q + 1'b1;
          state_d = ST_REQ;
        end else begin
          lose_d  = 1'b1;
          lives_d = lives_dec;
          state_d = lives_dec == 3'd0 ? ST_OVER : ST_REQ;
        end
      end
      ST_OVER: led_sel = LED_PAT;
      default: ;
    endcase
    // A start edge from any state begins a fresh game and overrides whatever the round was doing.
    if (start_rise) begin
      state_d   = ST_REQ;
      pattern_d = pattern_q;
      guess_d   = guess_q;
      score_d   = '0;
      lives_d   = 3'(START_LIVES);
      win_d     = 1'b0;
      lose_d    = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q   <= ST_IDLE;
      pattern_q <= '0;
      guess_q   <= '0;
      score_q   <= '0;
      lives_q   <= '0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
      over_q    <= 1'b0;
      start_q   <= start;
      submit_q  <= submit;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      guess_q   <= guess_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
      over_q    <= state_d == ST_OVER;
      start_q   <= start;
      submit_q  <= submit;
    end
  assign led = led_sel == LED_PAT ? pattern_q : led_sel == LED_GUESS ? guess : 8'h00;
  assign score      = score_q;
  assign lives      = lives_q;
  assign round_win  = win_q;
  assign round_lose = lose_q;
  assign game_over  = over_q;
endmodule
